uart_mmio_top: RTL and testbench
================================

Name: uart_mmio_top

Overview:
- Memory-mapped 8N1 UART peripheral on the core's simple valid-strobed bus.
- Holds a TX byte register, a control register that launches a frame, and an RX byte register with status flags.
- Sits at base address 0x1000_0000. Drives tx_pin and samples rx_pin.

Parameters:
- CLK_FREQUENCY, 50, system clock frequency in MHz.
- BAUD_RATE, 115200, line rate in bit/s. Bit period DIV = CLK_FREQUENCY*1_000_000/BAUD_RATE clocks, integer-truncated; DIV >= 4 is required. The 50 MHz / 5_000_000 configuration gives DIV = 10.

Ports:
- clk_in, input, 1, system clock, rising edge.
- rst_n, input, 1, reset; asynchronous, active-low.
- rx_pin, input, 1, serial receive line, idle high, asynchronous to clk_in.
- tx_pin, output, 1, serial transmit line, idle high.
- write_valid, input, 1, write strobe; sampled each rising edge.
- write_address, input, 32, byte address of write.
- write_data, input, 32, write data; only [7:0] used.
- read_valid, input, 1, read strobe (side effects only).
- read_address, input, 32, byte address of read.
- read_data, output, 32, read data, zero-extended.

Behaviour:
- Full 32-bit address decode; unmapped writes are ignored and unmapped reads return 0.
- 0x1000_0000 DATA:
  - Write: TXBUF <= write_data[7:0].
  - Read: returns RXBUF in [7:0].
- 0x1000_0001 STATUS (read-only):
  - bit0 tx_busy; bit1 rx_valid; bit2 rx_overrun; bit3 rx_frame_err; other bits 0.
- 0x1000_0002 CTRL (write):
  - write_data[0]=1 starts transmission of TXBUF if TX is idle.
  - Ignored while tx_busy=1. Not stored.
  - Reads return {31'b0, tx_busy}.
- read_data is combinational from read_address and current register state.
- A cycle with read_valid=1 at DATA clears rx_valid, rx_overrun and rx_frame_err at that clock edge.
- A write held across several clock edges is idempotent. A repeated CTRL start hits a busy transmitter and is ignored.
- Reset (rst_n low, asynchronous):
  - tx_pin=1; TXBUF=0, RXBUF=0; all flags 0; TX and RX FSMs in IDLE.
  - read_data reflects the zeroed registers.
  - Reset mid-frame aborts the frame immediately, with tx_pin forced to 1.
- TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE.
  - Start acceptance: on the accepting edge, TXBUF is copied to a shift register and tx_busy=1.
  - tx_pin goes 0 from the next cycle. Each bit is held exactly DIV clocks, LSB first, stop bit = 1.
  - tx_busy clears after the stop bit's DIV clocks. The frame lasts 10*DIV clocks.
  - Writing DATA mid-frame updates TXBUF only and does not alter the frame in flight.
- RX path:
  - rx_pin passes through a 2-flop synchronizer.
  - IDLE: a falling edge enters START; the line is sampled at DIV/2. If it is high, the start is treated as a glitch and the FSM returns to IDLE.
  - DATA: samples 8 bits every DIV clocks, LSB first.
  - STOP: sampled at DIV.
    - Stop = 1: RXBUF <= byte, rx_valid=1. If rx_valid was already 1, rx_overrun=1 and the new byte overwrites RXBUF.
    - Stop = 0: rx_frame_err=1, RXBUF and rx_valid unchanged.
  - Return to IDLE takes effect once the line is high.
- Simultaneous DATA read-clear and a new byte completing: the new byte wins, so rx_valid=1 and overrun=0.

Test Plan (CLK_FREQUENCY=50, BAUD_RATE=5_000_000, DIV=10, 20 ns clock):
- Reset pulse -> tx_pin=1; reads of 0x1000_0000 and 0x1000_0001 return 0.
- Write 0x000000A5 to 0x1000_0000, then 0x1 to 0x1000_0002 -> tx_pin low one cycle later for 200 ns, then 1,0,1,0,0,1,0,1 at 200 ns each, then stop high. STATUS bit0 is 1 for 2000 ns, then 0.
- Second CTRL start issued mid-frame -> ignored, with exactly one frame emitted. A DATA write of 0x3C mid-frame does not corrupt the 0xA5 frame; a subsequent start sends 0x3C.
- Drive rx_pin with a 0x5A frame at 200 ns/bit -> STATUS = 0x2 and DATA reads 0x5A. A read_valid pulse at DATA then gives STATUS = 0x0.
- Two RX frames (0x11, 0x22) without reading -> DATA=0x22, STATUS=0x6. Frame with stop bit 0 -> STATUS bit3=1 and RXBUF unchanged.
- 60 ns low glitch on rx_pin -> no reception and flags unchanged. rst_n asserted mid-TX frame -> tx_pin=1 immediately and STATUS=0.

Source files
------------

// File: rtl/uart_mmio_top.sv
// uart_mmio_top
//   Memory-mapped 8N1 UART on a simple valid-strobed bus, based at 0x1000_0000.
//   Register map (full 32-bit decode, anything else reads 0 / ignores writes):
//     0x1000_0000 DATA   W: TXBUF <= write_data[7:0]   R: RXBUF (clears RX flags when read_valid)
//     0x1000_0001 STATUS R: {rx_frame_err, rx_overrun, rx_valid, tx_busy}
//     0x1000_0002 CTRL   W: bit0=1 starts a TX frame if idle   R: {31'b0, tx_busy}
//
//   Bus handshake: a write takes effect on every rising edge where write_valid=1;
//   there is no ready/backpressure, so holding a write is harmless (DATA just
//   rewrites the same value, a held CTRL start finds the transmitter busy).
//   read_data is purely combinational from read_address; read_valid exists only
//   to carry the read-clear side effect of DATA.
//
//   Ports:
//     clk_in        system clock, rising edge
//     rst_n         asynchronous active-low reset
//     rx_pin        serial input, idle high, asynchronous to clk_in
//     tx_pin        serial output, idle high
//     write_valid / write_address / write_data   write strobe, address, data
//     read_valid / read_address / read_data      read strobe, address, data
//     dbg_tx_state  current TX FSM state (debug observation)
//     dbg_rx_state  current RX FSM state (debug observation)
module uart_mmio_top #(
  parameter int CLK_FREQUENCY = 50,
  parameter int BAUD_RATE     = 115200
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic        rx_pin,
  output logic        tx_pin,
  input  logic        write_valid,
  input  logic [31:0] write_address,
  input  logic [31:0] write_data,
  input  logic        read_valid,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic [1:0]  dbg_tx_state,
  output logic [2:0]  dbg_rx_state
);

  // Clocks per bit, integer-truncated.
  localparam int DIV = CLK_FREQUENCY * 1000000 / BAUD_RATE;
  localparam int CW  = $clog2(DIV + 1);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);

  localparam logic [31:0] ADDR_DATA   = 32'h1000_0000;
  localparam logic [31:0] ADDR_STATUS = 32'h1000_0001;
  localparam logic [31:0] ADDR_CTRL   = 32'h1000_0002;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;  // bad stop bit: wait for line high

  // Only the low byte of write_data is meaningful.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^write_data[31:8];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_data_hit;
  logic start_req;
  logic rd_clear;

  assign wr_data_hit = write_valid && (write_address == ADDR_DATA);
  assign start_req   = write_valid && (write_address == ADDR_CTRL) && write_data[0];
  assign rd_clear    = read_valid && (read_address == ADDR_DATA);

  logic [7:0] txbuf;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      txbuf <= 8'h00;
    end else if (wr_data_hit) begin
      txbuf <= write_data[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  logic [1:0]    tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_q;
  logic          tx_busy;

  assign tx_busy      = (tx_state != TX_IDLE);
  assign tx_pin       = tx_q;
  assign dbg_tx_state = tx_state;

  // tx_q is registered and changes on the same edge as the state, so the line
  // never glitches and the reset value drives the idle level immediately.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_q     <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (start_req) begin
            tx_shift <= txbuf;
            tx_state <= TX_START;
            tx_cnt   <= '0;
            tx_q     <= 1'b0;
          end
        end
        default: begin
          if (tx_cnt == DIV_LAST) begin
            tx_cnt <= '0;
            case (tx_state)
              TX_START: begin
                tx_state <= TX_DATA;
                tx_bit   <= 3'd0;
                tx_q     <= tx_shift[0];
              end
              TX_DATA: begin
                if (tx_bit == 3'd7) begin
                  tx_state <= TX_STOP;
                  tx_q     <= 1'b1;
                end else begin
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  tx_bit   <= tx_bit + 3'd1;
                  tx_q     <= tx_shift[1];
                end
              end
              default: begin
                tx_state <= TX_IDLE;
                tx_q     <= 1'b1;
              end
            endcase
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic          rx_s1;
  logic          rx_s2;
  logic          rx_prev;
  logic [2:0]    rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;

  assign dbg_rx_state = rx_state;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_pin;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Stop-bit sample point; both outcomes are decided on this one edge.
  logic stop_point;
  logic done_ok;
  logic done_err;

  assign stop_point = (rx_state == RX_STOP) && (rx_cnt == DIV_LAST);
  assign done_ok    = stop_point && rx_s2;
  assign done_err   = stop_point && !rx_s2;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          // Half a bit after the edge: a high line means it was a glitch.
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) begin
              rx_state <= RX_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_LAST) begin
            rx_cnt   <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_WAIT;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (rx_s2) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // RX buffer and flags. A byte completing on the same edge as a DATA read
  // wins over the read-clear: rx_valid stays set and overrun is cleared.
  // ---------------------------------------------------------------------------
  logic [7:0] rxbuf;
  logic       rx_valid;
  logic       rx_overrun;
  logic       rx_frame_err;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      rxbuf        <= 8'h00;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (done_ok) begin
        rxbuf      <= rx_shift;
        rx_valid   <= 1'b1;
        rx_overrun <= rd_clear ? 1'b0 : (rx_overrun | rx_valid);
      end else if (rd_clear) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end

      if (done_err) begin
        rx_frame_err <= 1'b1;
      end else if (rd_clear) begin
        rx_frame_err <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    read_data = 32'h0;
    case (read_address)
      ADDR_DATA:   read_data = {24'h0, rxbuf};
      ADDR_STATUS: read_data = {28'h0, rx_frame_err, rx_overrun, rx_valid, tx_busy};
      ADDR_CTRL:   read_data = {31'h0, tx_busy};
      default:     read_data = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_uart_mmio_top.sv
// tb_uart_mmio_top
//   Directed-plus-random bench for uart_mmio_top at DIV=10 (50 MHz / 5 Mbaud).
//   The reference model keeps the register file as plain variables and derives
//   the expected serial waveform from {stop, byte, start} bit vectors.
module tb_uart_mmio_top;

  localparam int DIV = 10;
  localparam logic [31:0] A_DATA = 32'h1000_0000;
  localparam logic [31:0] A_STAT = 32'h1000_0001;
  localparam logic [31:0] A_CTRL = 32'h1000_0002;

  // ---------------- clock / reset ----------------
  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_pin = 1'b1;
  logic        write_valid = 1'b0;
  logic [31:0] write_address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        read_valid = 1'b0;
  logic [31:0] read_address = 32'h0;
  wire         tx_pin;
  wire  [31:0] read_data;
  wire  [1:0]  dbg_tx_state;
  wire  [2:0]  dbg_rx_state;

  always #10 clk_in = ~clk_in;

  uart_mmio_top #(.CLK_FREQUENCY(50), .BAUD_RATE(5000000)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .rx_pin(rx_pin), .tx_pin(tx_pin),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
    .read_valid(read_valid), .read_address(read_address), .read_data(read_data),
    .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [7:0] m_txbuf = 8'h00;
  bit m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
  logic [7:0] exp_q[$];   // bytes accepted by the receiver, newest last

  function automatic logic [31:0] m_status();
    return {28'h0, m_ferr, m_ovr, m_valid, 1'b0};
  endfunction

  function automatic logic [31:0] m_rxbuf();
    if (exp_q.size() == 0) return 32'h0;
    return {24'h0, exp_q[$]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic read_chk(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    read_address = addr;
    #1;
    chk(tag, read_data, exp);
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk_in);
    write_valid = 1'b1; write_address = addr; write_data = data;
    @(negedge clk_in);
    write_valid = 1'b0;
    if (addr == A_DATA) m_txbuf = data[7:0];
  endtask

  task automatic read_clear();
    @(negedge clk_in);
    read_valid = 1'b1; read_address = A_DATA;
    @(negedge clk_in);
    read_valid = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
  endtask

  // Called at the negedge right after the accepting edge. Checks every cycle
  // of the frame, optionally injects a busy start and a DATA rewrite, then
  // checks the line stays idle (exactly one frame).
  task automatic tx_frame(input logic [7:0] b, input bit inject);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10 * DIV; k++) begin
      read_address = A_STAT;
      #1;
      chk("tx_line", {31'h0, tx_pin}, {31'h0, bits[k / DIV]});
      chk("tx_busy", {31'h0, read_data[0]}, 32'h1);
      write_valid = 1'b0;
      if (inject && k >= 30 && k <= 32) begin
        write_valid = 1'b1; write_address = A_CTRL; write_data = 32'h1;
      end
      if (inject && k >= 50 && k <= 51) begin
        write_valid = 1'b1; write_address = A_DATA; write_data = 32'h3C;
        m_txbuf = 8'h3C;
      end
      @(negedge clk_in);
    end
    write_valid = 1'b0;
    for (int k = 0; k < 2 * DIV; k++) begin
      read_address = A_STAT;
      #1;
      chk("tx_idle_line", {31'h0, tx_pin}, 32'h1);
      chk("tx_idle_busy", {31'h0, read_data[0]}, 32'h0);
      @(negedge clk_in);
    end
  endtask

  // Drives one 8N1 frame; clr_at >= 0 pulses a DATA read on that cycle.
  task automatic rx_send(input logic [7:0] b, input bit stop, input int clr_at);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int k = 0; k < 10 * DIV; k++) begin
      @(negedge clk_in);
      rx_pin = bits[k / DIV];
      read_valid = (k == clr_at);
      read_address = A_DATA;
    end
    @(negedge clk_in);
    rx_pin = 1'b1;
    read_valid = 1'b0;
    repeat (2 * DIV) @(negedge clk_in);
    if (clr_at >= 0) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    end
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_valid = 1'b1;
      exp_q.push_back(b);
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic rx_chk(input string tag);
    read_chk(A_STAT, m_status(), {tag, "_status"});
    read_chk(A_DATA, m_rxbuf(), {tag, "_data"});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] b;
    bit stop;

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clk_in);
    chk("rst_tx_pin", {31'h0, tx_pin}, 32'h1);
    read_chk(A_DATA, 32'h0, "rst_data");
    read_chk(A_STAT, 32'h0, "rst_status");
    read_chk(A_CTRL, 32'h0, "rst_ctrl");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    read_chk(32'h1000_0003, 32'h0, "unmapped_rd");

    // Aliased-address writes must do nothing.
    bus_write(A_DATA, 32'hFFFF_FFA5);
    bus_write(32'h0000_0000, 32'h0000_00FF);
    bus_write(32'h0000_0002, 32'h1);
    read_chk(A_STAT, 32'h0, "unmapped_start");
    chk("unmapped_tx", {31'h0, tx_pin}, 32'h1);

    // 0xA5 frame with busy restart and mid-frame DATA write, then 0x3C.
    bus_write(A_CTRL, 32'h1);
    tx_frame(8'hA5, 1'b1);
    bus_write(A_CTRL, 32'h1);
    tx_frame(8'h3C, 1'b0);

    // Random TX bytes.
    for (int i = 0; i < 3; i++) begin
      bus_write(A_DATA, $urandom_range(0, 255));
      b = m_txbuf;
      bus_write(A_CTRL, 32'h1);
      tx_frame(b, 1'b0);
    end

    // RX: single frame, then read-clear.
    rx_send(8'h5A, 1'b1, -1);
    read_chk(A_STAT, 32'h2, "rx5a_status");
    read_chk(A_DATA, 32'h5A, "rx5a_data");
    read_clear();
    read_chk(A_STAT, 32'h0, "rx5a_cleared");

    // Overrun: two frames without reading.
    rx_send(8'h11, 1'b1, -1);
    rx_send(8'h22, 1'b1, -1);
    read_chk(A_DATA, 32'h22, "ovr_data");
    read_chk(A_STAT, 32'h6, "ovr_status");

    // Read-clear on the completion edge of a new byte: byte wins, no overrun.
    rx_send(8'h9C, 1'b1, 97);
    read_chk(A_STAT, 32'h2, "race_status");
    read_chk(A_DATA, 32'h9C, "race_data");

    // Random RX traffic including bad stop bits and random reads.
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      rx_send(b, stop, -1);
      rx_chk("rand_rx");
      if ($urandom_range(0, 1) == 1) begin
        read_clear();
        rx_chk("rand_clr");
      end
    end

    // Frame error keeps RXBUF and rx_valid.
    rx_send(8'h77, 1'b1, -1);
    rx_send(8'hE1, 1'b0, -1);
    rx_chk("ferr");
    chk("ferr_bit3", {31'h0, read_data[3]}, 32'h0);
    read_chk(A_STAT, m_status(), "ferr_flags");
    chk("ferr_bit3_set", {31'h0, read_data[3]}, 32'h1);

    // 60 ns glitch: nothing received, flags untouched, receiver still usable.
    @(negedge clk_in);
    rx_pin = 1'b0;
    repeat (3) @(negedge clk_in);
    rx_pin = 1'b1;
    repeat (3 * DIV) @(negedge clk_in);
    rx_chk("glitch");
    rx_send(8'h3D, 1'b1, -1);
    rx_chk("post_glitch");

    // Reset mid-TX frame aborts immediately.
    bus_write(A_DATA, 32'h00);
    bus_write(A_CTRL, 32'h1);
    repeat (35) @(negedge clk_in);
    chk("pre_rst_tx", {31'h0, tx_pin}, 32'h0);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", {31'h0, tx_pin}, 32'h1);
    read_chk(A_STAT, 32'h0, "rst_mid_status");
    read_chk(A_DATA, 32'h0, "rst_mid_data");
    m_txbuf = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    exp_q.delete();
    @(negedge clk_in);
    rst_n = 1'b1;
    repeat (3 * DIV) @(negedge clk_in);
    chk("post_rst_tx", {31'h0, tx_pin}, 32'h1);
    read_chk(A_STAT, 32'h0, "post_rst_status");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
